mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the 32-bit CPU datapath.
- Walks each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath enables, mux selects, the ALU opcode, and the immediate-extension mode select (zero, sign, or LUI) consumed by the extension units.
- Sits between the instruction register and the datapath. Handshakes with the unified memory port via req/ready.

Parameters:
- EXT_W, 2, width of the extension-mode select
- ALUOP_W, 3, width of the ALU operation code

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  0 = PC addresses memory, 1 = ALU result addresses memory
- ir_write  out  1  load the instruction register
- pc_write  out  1  load the PC
- pc_src  out  2  00 = ALU (PC+4), 01 = branch target, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = extended immediate, 11 = extended immediate shifted left by 2
- ext_sel  out  EXT_W  00 = zero-extend, 01 = sign-extend, 10 = LUI (imm in upper 16 bits)
- alu_op  out  ALUOP_W  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 pass-B
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  select memory data for writeback
- reg_write  out  1  register-file write enable
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- state  out  4  current state, for debug and the board display

Behaviour:
- Outputs are Moore (decoded from the registered state and the latched decode fields). The exception is mem_req/ready completion, which is sampled the same cycle.
- Reset (rst=1 at the clock edge): state=FETCH. All enables are 0, all selects are 0, illegal=0. Reset overrides any pending memory handshake; mem_req drops the next cycle.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00. Stays while mem_ready=0. On mem_ready=1, ir_write=1 and pc_write=1 in that cycle, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, ext_sel=sign, alu_op=add (precomputes the branch target). Dispatch on opcode:
    - 0x00 → EXEC_R, if funct is in {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}; otherwise illegal.
    - 0x08 addi, 0x0C andi, 0x0D ori, 0x0F lui → EXEC_I.
    - 0x23 lw, 0x2B sw → ADDR.
    - 0x04 beq → BRANCH.
    - 0x02 j → JUMP.
    - Anything else: pulse illegal and return to FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct → WB_R.
  - WB_R: reg_dst=1, reg_write=1 → FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10. ext_sel is sign for addi, zero for andi/ori, LUI for lui. alu_op is add/and/or/pass-B respectively → WB_I.
  - WB_I: reg_dst=0, reg_write=1, ext_sel held → FETCH.
  - ADDR: alu_src_a=1, alu_src_b=10, ext_sel=sign, alu_op=add → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_req=1, iord=1. Waits for mem_ready → WB_MEM.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. Waits for mem_ready → FETCH.
  - WB_MEM: mem_to_reg=1, reg_dst=0, reg_write=1 → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub. pc_src=01, pc_write=alu_zero → FETCH.
  - JUMP: pc_src=10, pc_write=1 → FETCH.
- Decode fields (opcode, funct) are latched in DECODE. Later states do not depend on the IR inputs changing.
- Cycle counts with zero wait states: R-type 4, I-ALU 4, lw 5, sw 4, beq 3, j 3. Each wait cycle with mem_ready=0 adds 1 cycle in FETCH, MEM_RD or MEM_WR.
- mem_ready asserted outside FETCH, MEM_RD or MEM_WR is ignored.
- The state encoding is fixed as listed: FETCH=0 through JUMP=11. Codes 12–15 are unreachable and return to FETCH if ever entered.

Decomposition:
- Shared package/include holds:
  - the state encodings
  - the opcode and funct constants
  - the ALU_OP codes
  - the EXT_ZERO/EXT_SIGN/EXT_LUI codes (also used by the extension units)
- One natural sub-module, mc_alu_dec: combinational mapping of (opcode, funct, state) → alu_op and ext_sel.

Test Plan:
- Reset held for 2 cycles, then released with mem_ready=1 → state=FETCH, mem_req=1, all write enables 0 during reset.
- add (opcode 0x00, funct 0x20), mem_ready=1 → states FETCH, DECODE, EXEC_R, WB_R. reg_write=1 and reg_dst=1 only in WB_R. 4 cycles total.
- ori (opcode 0x0D) then lui (opcode 0x0F) → ext_sel=00 in EXEC_I/WB_I for ori and ext_sel=10 for lui. alu_op=011 for ori, 101 for lui.
- lw (opcode 0x23), mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles with iord=1. Then WB_MEM with mem_to_reg=1. 8 cycles total.
- beq with alu_zero=1 and then with alu_zero=0 → pc_write=1/pc_src=01 in BRANCH only in the first case. Both return to FETCH after 3 cycles.
- Opcode 0x3F, and also opcode 0x00 with funct 0x07 → illegal pulses for exactly 1 cycle. No reg_write or mem_req. Returns to FETCH.
- rst asserted mid-MEM_WR → next cycle state=FETCH and mem_we=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, instruction
// fields, ALU operation codes and immediate-extension modes.
package mc_ctrl_pkg;

    localparam int unsigned EXT_W   = 2;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned FIELD_W = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_WB_R   = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_I   = 4'd5,
        ST_ADDR   = 4'd6,
        ST_MEM_RD = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_WB_MEM = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11
    } state_t;

    localparam logic [FIELD_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [FIELD_W-1:0] OP_J     = 6'h02;
    localparam logic [FIELD_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [FIELD_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [FIELD_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [FIELD_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [FIELD_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [FIELD_W-1:0] OP_LW    = 6'h23;
    localparam logic [FIELD_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FIELD_W-1:0] FN_ADD = 6'h20;
    localparam logic [FIELD_W-1:0] FN_SUB = 6'h22;
    localparam logic [FIELD_W-1:0] FN_AND = 6'h24;
    localparam logic [FIELD_W-1:0] FN_OR  = 6'h25;
    localparam logic [FIELD_W-1:0] FN_SLT = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_PASSB = 3'b101;

    localparam logic [EXT_W-1:0] EXT_ZERO = 2'b00;
    localparam logic [EXT_W-1:0] EXT_SIGN = 2'b01;
    localparam logic [EXT_W-1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP = 2'b10;

    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SL2 = 2'b11;

    // Supported R-type function codes
    function automatic logic rtype_funct_ok(input logic [FIELD_W-1:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    // First state after DECODE; ST_FETCH marks an unsupported encoding
    function automatic state_t dispatch(input logic [FIELD_W-1:0] opcode,
                                        input logic [FIELD_W-1:0] funct);
        state_t target;
        target = ST_FETCH;
        case (opcode)
            OP_RTYPE: target = rtype_funct_ok(funct) ? ST_EXEC_R : ST_FETCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: target = ST_EXEC_I;
            OP_LW, OP_SW: target = ST_ADDR;
            OP_BEQ: target = ST_BRANCH;
            OP_J: target = ST_JUMP;
            default: target = ST_FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation and immediate-extension mode as a function of the current
// state and the latched decode fields.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  state_t             state,
    input  logic [FIELD_W-1:0] opcode,
    input  logic [FIELD_W-1:0] funct,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [EXT_W-1:0]   ext_sel
);

    always_comb begin
        alu_op  = ALU_ADD;
        ext_sel = EXT_ZERO;
        case (state)
            ST_DECODE, ST_ADDR: ext_sel = EXT_SIGN;
            ST_EXEC_R: begin
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            // Extension mode stays stable through writeback of I-type ALU ops
            ST_EXEC_I, ST_WB_I: begin
                case (opcode)
                    OP_ADDI: ext_sel = EXT_SIGN;
                    OP_LUI:  ext_sel = EXT_LUI;
                    default: ext_sel = EXT_ZERO;
                endcase
                if (state == ST_EXEC_I) begin
                    case (opcode)
                        OP_ANDI: alu_op = ALU_AND;
                        OP_ORI:  alu_op = ALU_OR;
                        OP_LUI:  alu_op = ALU_PASSB;
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            ST_BRANCH: alu_op = ALU_SUB;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [EXT_W-1:0]   ext_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal,
    output logic [3:0]         state
);

    state_t               cur;
    state_t               nxt;
    state_t               dec_target;
    logic [FIELD_W-1:0]   op_q;
    logic [FIELD_W-1:0]   funct_q;
    logic                 illegal_q;
    logic [ALUOP_W-1:0]   dec_alu_op;
    logic [EXT_W-1:0]     dec_ext_sel;

    assign dec_target = dispatch(opcode, funct);
    assign state      = cur;

    mc_alu_dec u_alu_dec (
        .state   (cur),
        .opcode  (op_q),
        .funct   (funct_q),
        .alu_op  (dec_alu_op),
        .ext_sel (dec_ext_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= ST_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    // Decode fields are captured on leaving DECODE so later states ignore the IR
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (cur == ST_DECODE) && (dec_target == ST_FETCH);
            if (cur == ST_DECODE) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
        end
    end

    always_comb begin
        nxt = ST_FETCH;
        case (cur)
            ST_FETCH:  nxt = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: nxt = dec_target;
            ST_EXEC_R: nxt = ST_WB_R;
            ST_EXEC_I: nxt = ST_WB_I;
            ST_ADDR:   nxt = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: nxt = mem_ready ? ST_WB_MEM : ST_MEM_RD;
            ST_MEM_WR: nxt = mem_ready ? ST_FETCH : ST_MEM_WR;
            default:   nxt = ST_FETCH;
        endcase
    end

    // Moore decode of the datapath controls; reset forces everything idle
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RT;
        ext_sel    = EXT_ZERO;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            alu_op  = dec_alu_op;
            ext_sel = dec_ext_sel;
            illegal = illegal_q;
            case (cur)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: alu_src_b = SRC_B_IMM_SL2;
                ST_EXEC_R: alu_src_a = 1'b1;
                ST_WB_R: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                ST_EXEC_I, ST_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                ST_WB_I: reg_write = 1'b1;
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                ST_WB_MEM: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    pc_src    = PC_SRC_BR;
                    pc_write  = alu_zero;
                end
                ST_JUMP: begin
                    pc_src   = PC_SRC_JUMP;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: each instruction is expanded into an
// expected per-cycle trace from the instruction-class rules and replayed.
module tb_mc_ctrl;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_EXEC_R = 2;
    localparam int S_WB_R   = 3;
    localparam int S_EXEC_I = 4;
    localparam int S_WB_I   = 5;
    localparam int S_ADDR   = 6;
    localparam int S_MEM_RD = 7;
    localparam int S_MEM_WR = 8;
    localparam int S_WB_MEM = 9;
    localparam int S_BRANCH = 10;
    localparam int S_JUMP   = 11;

    localparam int C_ILL = 0;
    localparam int C_R   = 1;
    localparam int C_I   = 2;
    localparam int C_LW  = 3;
    localparam int C_SW  = 4;
    localparam int C_BEQ = 5;
    localparam int C_J   = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
    logic [1:0] pc_src, alu_src_b, ext_sel;
    logic [2:0] alu_op;
    logic [3:0] state;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_sel    (ext_sel),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ext_sel;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } obs_t;

    typedef struct {
        int         st;
        logic       rdy;
        logic       zero;
        logic [5:0] op;
        logic [5:0] fn;
        obs_t       o;
    } step_t;

    step_t plan[$];
    int    n_checks = 0;
    int    n_fail = 0;
    bit    illegal_pending = 1'b0;

    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? C_R : C_ILL;
        if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0F}) return C_I;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        if (op == 6'h04) return C_BEQ;
        if (op == 6'h02) return C_J;
        return C_ILL;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b001;
            6'h24:   return 3'b010;
            6'h25:   return 3'b011;
            6'h2A:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // {ext_sel, alu_op} for I-type ALU instructions
    function automatic logic [4:0] i_ctl(input logic [5:0] op);
        case (op)
            6'h0C:   return {2'b00, 3'b010};
            6'h0D:   return {2'b00, 3'b011};
            6'h0F:   return {2'b10, 3'b101};
            default: return {2'b01, 3'b000};
        endcase
    endfunction

    // Cycle with random don't-care IR, zero flag and (where ignored) mem_ready
    task automatic push(input int st, input logic rdy, input obs_t o);
        step_t s;
        s.st = st;
        s.rdy = rdy;
        s.zero = 1'($urandom);
        s.op = 6'($urandom);
        s.fn = 6'($urandom);
        s.o = o;
        plan.push_back(s);
    endtask

    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                              input int fw, input int mw);
        obs_t o;
        int c;
        logic [4:0] ic;
        c = cls(op, fn);
        ic = i_ctl(op);
        for (int i = 0; i <= fw; i++) begin
            o = '0;
            o.mem_req = 1'b1;
            o.alu_src_b = 2'b01;
            o.ir_write = (i == fw);
            o.pc_write = (i == fw);
            o.illegal = (i == 0) && illegal_pending;
            push(S_FETCH, i == fw, o);
        end
        illegal_pending = 1'b0;
        o = '0;
        o.alu_src_b = 2'b11;
        o.ext_sel = 2'b01;
        push(S_DECODE, 1'($urandom), o);
        plan[plan.size()-1].op = op;
        plan[plan.size()-1].fn = fn;
        case (c)
            C_R: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_op = r_alu(fn);
                push(S_EXEC_R, 1'($urandom), o);
                o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1;
                push(S_WB_R, 1'($urandom), o);
            end
            C_I: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.ext_sel = ic[4:3]; o.alu_op = ic[2:0];
                push(S_EXEC_I, 1'($urandom), o);
                o = '0; o.reg_write = 1'b1; o.ext_sel = ic[4:3];
                push(S_WB_I, 1'($urandom), o);
            end
            C_LW, C_SW: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.ext_sel = 2'b01;
                push(S_ADDR, 1'($urandom), o);
                for (int i = 0; i <= mw; i++) begin
                    o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (c == C_SW);
                    push((c == C_SW) ? S_MEM_WR : S_MEM_RD, i == mw, o);
                end
                if (c == C_LW) begin
                    o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
                    push(S_WB_MEM, 1'($urandom), o);
                end
            end
            C_BEQ: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_op = 3'b001;
                o.pc_src = 2'b01; o.pc_write = zero;
                push(S_BRANCH, 1'($urandom), o);
                plan[plan.size()-1].zero = zero;
            end
            C_J: begin
                o = '0; o.pc_src = 2'b10; o.pc_write = 1'b1;
                push(S_JUMP, 1'($urandom), o);
            end
            default: illegal_pending = 1'b1;
        endcase
    endtask

    task automatic chk_state(input string tag, input int exp);
        n_checks++;
        assert (state === 4'(exp)) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, exp);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t exp);
        obs_t got;
        got = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               ext_sel, alu_op, reg_dst, mem_to_reg, reg_write, illegal};
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s outputs (st %0d): observed %05h expected %05h", tag, state, got, exp);
        end
    endtask

    // Replays up to limit planned cycles (negative = all); entered just after a rising edge
    task automatic run_plan(input string tag, input int limit);
        step_t s;
        int n;
        n = 0;
        while (plan.size() > 0 && (limit < 0 || n < limit)) begin
            s = plan.pop_front();
            mem_ready = s.rdy;
            alu_zero = s.zero;
            opcode = s.op;
            funct = s.fn;
            @(negedge clk);
            chk_state(tag, s.st);
            chk_obs(tag, s.o);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic zero, input int fw, input int mw);
        plan_instr(op, fn, zero, fw, mw);
        run_plan(tag, -1);
    endtask

    logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] other_op [8] = '{6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};

    initial begin
        obs_t o;
        logic [5:0] rop, rfn;
        int sel;

        rst = 1'b1;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        opcode = '0;
        funct = '0;
        #2;
        chk_obs("reset_pre_edge", '0);
        @(negedge clk);
        chk_state("reset", S_FETCH);
        chk_obs("reset", '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
        do_instr("ori", 6'h0D, 6'h00, 1'b0, 0, 0);
        do_instr("lui", 6'h0F, 6'h3F, 1'b0, 0, 0);
        do_instr("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3);
        do_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
        do_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 0, 0);
        do_instr("illegal_op", 6'h3F, 6'h20, 1'b0, 0, 0);
        do_instr("illegal_funct", 6'h00, 6'h07, 1'b0, 1, 0);
        do_instr("j", 6'h02, 6'h00, 1'b0, 0, 0);
        do_instr("sw_fetch_wait", 6'h2B, 6'h00, 1'b0, 2, 1);
        do_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0);
        do_instr("andi", 6'h0C, 6'h00, 1'b0, 0, 0);
        do_instr("sub", 6'h00, 6'h22, 1'b0, 0, 0);
        do_instr("slt", 6'h00, 6'h2A, 1'b0, 1, 0);

        // Reset arriving while a store is still waiting on memory
        plan_instr(6'h2B, 6'h00, 1'b0, 0, 3);
        run_plan("sw_pre_rst", 5);
        plan.delete();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk_obs("rst_in_mem_wr", '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk_state("after_rst", S_FETCH);
        o = '0;
        o.mem_req = 1'b1;
        o.alu_src_b = 2'b01;
        chk_obs("after_rst", o);
        @(posedge clk);
        #1;
        illegal_pending = 1'b0;

        for (int k = 0; k < 60; k++) begin
            sel = int'($urandom_range(0, 9));
            rop = 6'($urandom);
            rfn = 6'($urandom);
            if (sel == 0) begin
                rop = 6'h00;
                rfn = legal_fn[$urandom_range(0, 4)];
            end else if (sel == 1) begin
                rop = 6'h00;
            end else if (sel < 9) begin
                rop = other_op[$urandom_range(0, 7)];
            end
            do_instr("random", rop, rfn, 1'($urandom), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)));
        end
        do_instr("final_j", 6'h02, 6'h00, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
